gather_fifo: RTL and testbench

- Mirror of the multi-push queue: accepts at most 1 element per cycle and releases up to 4 elements per cycle as a packed group.
- Sits between a scalar producer (e.g. a decode/issue stage emitting one op per cycle) and a superscalar consumer that drains bundles of 1-4.
- Output is first-word-fall-through: the oldest 4 elements are always visible, with a count of how many are valid.

---
 rtl/cherry_fifo_pkg.sv | 19 +
 rtl/gather_fifo.sv | 109 ++++++++++
 tb/tb_gather_fifo.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cherry_fifo_pkg.sv
// rtl/cherry_fifo_pkg.sv - shared constants and helpers for the cherry multi-element queues
package cherry_fifo_pkg;

    localparam int BUNDLE_W = 4;

    // Count fields are encoded as count-1 so a 2-bit field spans 1..4 elements.
    function automatic logic [1:0] cnt_enc(input int n);
        return 2'(n - 1);
    endfunction

    function automatic logic [2:0] cnt_dec(input logic [1:0] f);
        return {1'b0, f} + 3'd1;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/gather_fifo.sv
// rtl/gather_fifo.sv - 1-in / up-to-4-out first-word-fall-through queue; GATHER_FIFO_ERR_EN adds sticky err
module gather_fifo
    import cherry_fifo_pkg::*;
#(
    parameter int LINE  = 18,
    parameter int DEPTH = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [LINE-1:0] dat_w,
    input  logic            re,
    input  logic [1:0]      re_count,
    output logic [LINE-1:0] dat_r_1,
    output logic [LINE-1:0] dat_r_2,
    output logic [LINE-1:0] dat_r_3,
    output logic [LINE-1:0] dat_r_4,
    output logic [2:0]      avail,
    output logic            full,
    output logic            empty,
    output logic            full_soon,
`ifdef GATHER_FIFO_ERR_EN
    output logic            empty_soon,
    output logic            err
`else
    output logic            empty_soon
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [LINE-1:0] mem [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [PW-1:0]   count;
    logic [PW-1:0]   n_req;
    logic [PW-1:0]   n_pop;
    logic            push_ok;
    logic            pop_trunc;
    logic [LINE-1:0] rd [BUNDLE_W];

    // The wrap bit makes head-tail span 0..DEPTH without an extra counter.
    assign count      = head_q - tail_q;
    assign full       = (count == PW'(DEPTH));
    assign empty      = (count == '0);
    assign full_soon  = (count >= PW'(DEPTH - BUNDLE_W));
    assign empty_soon = (count <= PW'(BUNDLE_W));
    assign avail      = (count >= PW'(BUNDLE_W)) ? 3'(BUNDLE_W) : count[2:0];

    assign push_ok    = we && !full;
    assign n_req      = PW'(cnt_dec(re_count));
    assign pop_trunc  = re && (n_req > count);

    always_comb begin
        n_pop  = '0;
        head_d = head_q;
        if (re) begin
            n_pop = pop_trunc ? count : n_req;
        end
        if (push_ok) begin
            head_d = head_q + PW'(1);
        end
        tail_d = tail_q + n_pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Storage is deliberately left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[head_q[AW-1:0]] <= dat_w;
        end
    end

    for (genvar k = 0; k < BUNDLE_W; k++) begin : g_rd
        logic [AW-1:0] idx;
        assign idx   = tail_q[AW-1:0] + AW'(k);
        assign rd[k] = mem[idx];
    end

    assign dat_r_1 = rd[0];
    assign dat_r_2 = rd[1];
    assign dat_r_3 = rd[2];
    assign dat_r_4 = rd[3];

`ifdef GATHER_FIFO_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((we && full) || pop_trunc) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_gather_fifo.sv
// tb/tb_gather_fifo.sv - randomized and directed bench for gather_fifo against a queue model
module tb_gather_fifo;

    localparam int LINE  = 18;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            we = 1'b0;
    logic [LINE-1:0] dat_w = '0;
    logic            re = 1'b0;
    logic [1:0]      re_count = '0;
    logic [LINE-1:0] dat_r_1, dat_r_2, dat_r_3, dat_r_4;
    logic [2:0]      avail;
    logic            full, empty, full_soon, empty_soon;
    logic            err;

    gather_fifo #(.LINE(LINE), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .dat_w      (dat_w),
        .re         (re),
        .re_count   (re_count),
        .dat_r_1    (dat_r_1),
        .dat_r_2    (dat_r_2),
        .dat_r_3    (dat_r_3),
        .dat_r_4    (dat_r_4),
        .avail      (avail),
        .full       (full),
        .empty      (empty),
        .full_soon  (full_soon),
`ifdef GATHER_FIFO_ERR_EN
        .empty_soon (empty_soon),
        .err        (err)
`else
        .empty_soon (empty_soon)
`endif
    );

`ifndef GATHER_FIFO_ERR_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;

    int              nvec = 0;
    int              nerr = 0;
    logic [LINE-1:0] q [$];
    bit              err_m = 0;
    logic [LINE-1:0] dr [4];

    assign dr[0] = dat_r_1;
    assign dr[1] = dat_r_2;
    assign dr[2] = dat_r_3;
    assign dr[3] = dat_r_4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        int av;
        n  = q.size();
        av = (n < 4) ? n : 4;
        check({tag, ".empty"},      32'(empty),      32'(n == 0));
        check({tag, ".full"},       32'(full),       32'(n == DEPTH));
        check({tag, ".full_soon"},  32'(full_soon),  32'(n >= DEPTH - 4));
        check({tag, ".empty_soon"}, 32'(empty_soon), 32'(n <= 4));
        check({tag, ".avail"},      32'(avail),      32'(av));
        for (int k = 0; k < av; k++)
            check($sformatf("%s.dat_r_%0d", tag, k + 1), 32'(dr[k]), 32'(q[k]));
`ifdef GATHER_FIFO_ERR_EN
        check({tag, ".err"}, 32'(err), 32'(err_m));
`endif
    endtask

    // One clock: apply inputs, advance the model on pre-edge occupancy, check after the edge.
    task automatic cycle(input bit w, input logic [LINE-1:0] d, input bit r,
                         input logic [1:0] rc, input string tag);
        int n;
        int want;
        int take;
        we = w; dat_w = d; re = r; re_count = rc;
        n    = q.size();
        want = int'(rc) + 1;
        take = r ? ((want < n) ? want : n) : 0;
        if ((w && n == DEPTH) || (r && want > n)) err_m = 1;
        for (int i = 0; i < take; i++) void'(q.pop_front());
        if (w && n < DEPTH) q.push_back(d);
        @(posedge clk);
        #1;
        we = 0; re = 0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        q.delete();
        err_m = 0;
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1;
        do_reset("rst0");
        check("rst0.empty_c", 32'(empty), 32'd1);
        check("rst0.avail_c", 32'(avail), 32'd0);

        for (int i = 0; i < 6; i++) cycle(1, LINE'(8'h11 + i), 0, 0, "push6");
        check("fwft.d1", 32'(dat_r_1), 32'h11);
        check("fwft.d4", 32'(dat_r_4), 32'h14);
        cycle(0, '0, 1, 3, "pop4");
        check("pop4.avail_c", 32'(avail), 32'd2);
        check("pop4.d1_c", 32'(dat_r_1), 32'h15);

        do_reset("rst1");
        for (int i = 0; i < DEPTH + 1; i++) cycle(1, LINE'(32'h100 + i), 0, 0, "fill");
        check("fill.full_c", 32'(full), 32'd1);
`ifdef GATHER_FIFO_ERR_EN
        check("fill.err_c", 32'(err), 32'd1);
`endif
        for (int i = 0; i < DEPTH / 4; i++) cycle(0, '0, 1, 3, "drain");
        check("drain.empty_c", 32'(empty), 32'd1);

        do_reset("rst2");
        cycle(1, 18'hA, 0, 0, "pushA");
        cycle(1, 18'hB, 0, 0, "pushB");
        cycle(0, '0, 1, 3, "overpop");
        check("overpop.empty_c", 32'(empty), 32'd1);
`ifdef GATHER_FIFO_ERR_EN
        check("overpop.err_c", 32'(err), 32'd1);
`endif
        cycle(0, '0, 1, 0, "pop_empty");

        do_reset("rst3");
        cycle(1, 18'h6, 0, 0, "push6v");
        cycle(1, 18'h7, 1, 0, "simul");
        check("simul.d1_c", 32'(dat_r_1), 32'h7);

        do_reset("rst4");
        for (int i = 0; i < 62; i++) begin
            cycle(1, LINE'(i), 0, 0, "wrap_push");
            cycle(0, '0, 1, 0, "wrap_pop");
        end
        for (int i = 0; i < 4; i++) cycle(1, LINE'(8'h20 + i), 0, 0, "wrap_fill");
        check("wrap.d1_c", 32'(dat_r_1), 32'h20);
        check("wrap.d3_c", 32'(dat_r_3), 32'h22);
        check("wrap.d4_c", 32'(dat_r_4), 32'h23);
        cycle(1, 18'h24, 0, 0, "wrap_more");
        #2;
        do_reset("rst_mid");

        for (int blk = 0; blk < 20; blk++) begin
            int pw;
            int pr;
            pw = (blk % 2 == 0) ? 85 : 30;
            pr = (blk % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 150; i++)
                cycle($urandom_range(0, 99) < pw, LINE'($urandom), $urandom_range(0, 99) < pr,
                      2'($urandom_range(0, 3)), "rand");
            if (blk == 9) begin
                #2;
                do_reset("rand_rst");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
